stream_packer: RTL

Downstream consumer of the team's FIFO: pops narrow words over the FIFO's valid/ready read port and packs RATIO consecutive words into one wide output beat with a per-lane keep mask. Partial beats are emitted on an explicit flush or after an idle timeout, so trailing data never stalls in the accumulator. The output is a registered valid/ready stream feeding wide consumers (bus masters, wide buffers).

---
 rtl/stream_pkg.sv | 24 ++
 rtl/stream_packer_idle_timer.sv | 30 +++
 rtl/stream_packer.sv | 114 +++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream packer: beat-load selection and the
// lane-count to keep-mask conversion.
package stream_pkg;

    localparam int MAX_LANES = 64;

    typedef enum logic [1:0] {
        LOAD_NONE,
        LOAD_FULL_IN,
        LOAD_FULL_ACC,
        LOAD_PARTIAL
    } load_e;

    // Thermometer mask: the low n bits set.
    function automatic logic [MAX_LANES-1:0] thermo_mask(input int n);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int k = 0; k < MAX_LANES; k++) begin
            if (k < n) m[k] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/stream_packer_idle_timer.sv
// Saturating idle counter: clear has priority, counts up on inc, and reports
// done while the count sits at TIMEOUT.
module idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic done
);

    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LIMIT = IW'(TIMEOUT);

    logic [IW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && count != LIMIT) begin
            count <= count + IW'(1);
        end
    end

    assign done = (count == LIMIT);

endmodule

// File: rtl/stream_packer.sv
// Packs RATIO narrow words from a valid/ready source into one wide registered
// beat with a lane keep mask; partial beats leave on flush or idle timeout.
module stream_packer
    import stream_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_val,
    output logic                      in_rdy,
    input  logic                      flush,
    output logic [IN_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]          out_keep,
    output logic                      out_val,
    input  logic                      out_rdy
);

    localparam int CW = $clog2(RATIO + 1);
    localparam int LW = $clog2(RATIO);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [LW-1:0] lane_t;

    localparam cnt_t FULL = cnt_t'(RATIO);
    localparam cnt_t LAST = cnt_t'(RATIO - 1);

    cnt_t                      cnt;
    logic [IN_WIDTH-1:0]       acc [RATIO];
    logic                      slot_free;
    logic                      partial;
    logic                      idle_done;
    logic                      flush_cond;
    logic                      accept;
    load_e                     load;
    logic [IN_WIDTH*RATIO-1:0] beat_data;
    logic [RATIO-1:0]          beat_keep;

    assign slot_free  = !out_val || out_rdy;
    assign partial    = (cnt != '0) && (cnt < FULL);
    assign flush_cond = (flush || idle_done) && partial && slot_free;
    assign in_rdy     = !reset && (cnt < FULL) && !flush_cond;
    assign accept     = in_val && in_rdy;

    // A stalled full beat outranks everything; flush and accept never coincide.
    always_comb begin
        load = LOAD_NONE;
        if (cnt == FULL && slot_free) begin
            load = LOAD_FULL_ACC;
        end else if (flush_cond) begin
            load = LOAD_PARTIAL;
        end else if (accept && cnt == LAST && slot_free) begin
            load = LOAD_FULL_IN;
        end
    end

    always_comb begin
        beat_keep = '1;
        if (load == LOAD_PARTIAL) begin
            beat_keep = RATIO'(thermo_mask(int'(cnt)));
        end
        for (int k = 0; k < RATIO; k++) begin
            beat_data[k*IN_WIDTH +: IN_WIDTH] = beat_keep[k] ? acc[k] : '0;
        end
        if (load == LOAD_FULL_IN) begin
            beat_data[(RATIO-1)*IN_WIDTH +: IN_WIDTH] = in_data;
        end
    end

    // NOTE: the accumulator is pure storage gated by cnt, so it carries no
    // reset; stale lanes are masked out of every beat.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc[lane_t'(cnt)] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            out_val  <= 1'b0;
            out_data <= '0;
            out_keep <= '0;
        end else begin
            if (load != LOAD_NONE) begin
                out_data <= beat_data;
                out_keep <= beat_keep;
                out_val  <= 1'b1;
            end else if (out_rdy) begin
                out_val  <= 1'b0;
            end

            if (load != LOAD_NONE) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + cnt_t'(1);
            end
        end
    end

    idle_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_idle_timer (
        .clk  (clk),
        .reset(reset),
        .clear(accept || (load != LOAD_NONE) || (cnt == '0)),
        .inc  (partial),
        .done (idle_done)
    );

endmodule
